motor3_commutation_ctrl: RTL
============================

Name: motor3_commutation_ctrl

Overview:
Six-step (trapezoidal) commutation controller for the three motor3_irs2007s_driver half-bridge instances in motor602_real.
- Turns operator controls (start, force stop, invert rotation, freq/power inc/dec) into per-phase 2-bit drive commands (down1_up2 encoding).
- Handles step timing (NCO), PWM power gating on high sides, dead-time insertion, and braking.
- Sits between the front-panel/host control inputs and the three driver instances.

Parameters:
CLK_HZ, 1000000, clock frequency in Hz.
STEP_DIV, CLK_HZ/6 (166666), NCO modulus; one commutation step per STEP_DIV/freq cycles.
FREQ_MIN, 1, minimum electrical frequency (Hz).
FREQ_MAX, 1000, maximum electrical frequency (Hz).
FREQ_INIT, 10, reset value of the frequency register.
PWM_PERIOD, 50, PWM period in clocks (20 kHz at 1 MHz); also the maximum power value.
DEADTIME, 2, all-off cycles inserted before braking.
BRAKE_CYCLES, 100000, duration of low-side braking.

Ports:
clkI  in  1  system clock, 1 MHz.
nRstI  in  1  asynchronous active-low reset.
m3startI  in  1  level input; each rising edge is one start event.
m3forceStopI  in  1  level input; each rising edge is one force-stop event.
m3invRotateI  in  1  level: 0 = forward, 1 = reverse; sampled at every step advance.
m3freqINCi  in  1  rising edge: freq+1.
m3freqDECi  in  1  rising edge: freq-1.
m3powerINCi  in  1  rising edge: power+1.
m3powerDECi  in  1  rising edge: power-1.
aDrvO  out  2  phase A command: 0 = off, 1 = low side on, 2 = high side on; 3 is never driven.
bDrvO  out  2  phase B command, same encoding.
cDrvO  out  2  phase C command, same encoding.
stepO  out  3  current commutation step, 0..5.
runO  out  1  1 while in RUN.
freqO  out  10  current frequency register.
powerO  out  6  current power register.

Behaviour:
- Reset (async, nRstI = 0):
  - state = IDLE; all Drv outputs = 0; stepO = 0; runO = 0.
  - freq = FREQ_INIT; power = 0; NCO acc = 0; PWM counter = 0; edge-detect registers = 0.
- Input handling:
  - All control inputs are registered once and then rising-edge detected; events act one cycle after the edge.
- Frequency and power registers:
  - freq saturates at FREQ_MIN..FREQ_MAX.
  - power saturates at 0..PWM_PERIOD.
  - INC and DEC events in the same cycle: no change.
  - Both registers are adjustable in any state; new values take effect on the next cycle.
- State machine:
  - IDLE: all outputs off.
    - start event -> RUN with step = 0, acc = 0.
  - RUN:
    - Each cycle, acc_n = acc + freq.
    - If acc_n >= STEP_DIV: acc <= acc_n - STEP_DIV and step advances by one: +1 mod 6 when m3invRotateI = 0, -1 mod 6 when it is 1.
    - Otherwise acc <= acc_n.
    - start events in RUN are ignored.
  - force-stop event in RUN -> DEAD.
  - DEAD: all phases = 0 for DEADTIME cycles, then -> BRAKE.
  - BRAKE: all phases = 1 (low sides shorted) for BRAKE_CYCLES, then -> IDLE.
    - start events are ignored in DEAD and BRAKE.
  - force stop in IDLE: no effect.
  - force stop and start in the same cycle: force stop wins.
- Step table, phases (A, B, C):
  - step 0: (H, L, off); step 1: (H, off, L); step 2: (off, H, L)
  - step 3: (L, H, off); step 4: (L, off, H); step 5: (off, L, H)
  - Adjacent steps never swap H <-> L on the same phase, so no dead time is needed between steps.
- PWM gating:
  - Free-running counter pwm in 0..PWM_PERIOD-1.
  - In RUN, a phase at H outputs 2 only while pwm < power; otherwise it outputs 0.
  - L phases are ungated.
  - power = 0: high sides never on. power = PWM_PERIOD: high sides always on.
- Output timing: drive outputs are registered, one cycle after the state/step/pwm update.

Optional Feature:
MOTOR3_SOFTSTART_EN:
- Defined: an effective-power register resets to 0 on entry to RUN and increments by 1 every 1000 cycles until it equals power. A power decrease below the current effective value takes effect immediately. PWM gating compares against effective power.
- Not defined: gating compares directly against power.

Decomposition:
- Package motor3_pkg:
  - DRV_OFF = 2'd0, DRV_LOW = 2'd1, DRV_HIGH = 2'd2.
  - state encoding: IDLE, RUN, DEAD, BRAKE.
  - six-entry step table constant.
  - FREQ_MIN / FREQ_MAX defaults.
- One sub-module, motor3_pwm_gen: PWM counter plus compare; outputs the gate-enable bit.

Test Plan:
1. Reset, then start with freq = 10, power = 50 -> runO = 1; step advances every 16666 or 16667 cycles; 6 steps (one electrical revolution) = 100000 ±1 cycles; phase outputs match the table; no 3 code ever driven.
2. freq = 1000, power = 25, forward then m3invRotateI = 1 -> steps 0,1,2,... every ~167 cycles, then reverse order; each high phase is 2 for 25 of every 50 cycles.
3. 1005 freqINC edges from FREQ_INIT -> freqO = 1000; 20 freqDEC edges from 10 -> freqO = 1. Simultaneous INC + DEC -> no change; powerINC ×60 -> powerO = 50.
4. Force stop in RUN -> DEADTIME = 2 cycles of all 0, then 100000 cycles of all 1, then IDLE with all 0. A start pulse during BRAKE is ignored.
5. Start and force stop asserted in the same cycle from IDLE -> remains IDLE. nRstI asserted mid-BRAKE -> outputs are 0 immediately (async) and freq = 10.

Source files
------------

// File: rtl/motor3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor3_pkg
//  Description : Shared types and constants for the motor3 six-step
//                commutation controller: drive codes, FSM states, the
//                six-entry commutation table and frequency-range defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package motor3_pkg;

    // Per-phase half-bridge command (down1_up2 encoding); 2'd3 is never used
    localparam logic [1:0] DRV_OFF  = 2'd0;
    localparam logic [1:0] DRV_LOW  = 2'd1;
    localparam logic [1:0] DRV_HIGH = 2'd2;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2,
        ST_BRAKE = 2'd3
    } motorState_t;

    // Electrical frequency range defaults (Hz)
    localparam int FREQ_MIN_DFLT = 1;
    localparam int FREQ_MAX_DFLT = 1000;

    // Commutation table, entry = {A, B, C}. Neighbouring steps never swap
    // H and L on one phase, so no dead time is needed between steps.
    localparam logic [0:5][5:0] STEP_TABLE = {
        {DRV_HIGH, DRV_LOW,  DRV_OFF },   // step 0
        {DRV_HIGH, DRV_OFF,  DRV_LOW },   // step 1
        {DRV_OFF,  DRV_HIGH, DRV_LOW },   // step 2
        {DRV_LOW,  DRV_HIGH, DRV_OFF },   // step 3
        {DRV_LOW,  DRV_OFF,  DRV_HIGH},   // step 4
        {DRV_OFF,  DRV_LOW,  DRV_HIGH}    // step 5
    };

    // Table lookup with PWM gating: high sides drop to OFF when the gate is
    // closed, low sides are left untouched. Out-of-range steps give all-off.
    function automatic logic [5:0] stepDrive(input logic [2:0] step, input logic highEn);
        logic [5:0] ent;
        ent = (step <= 3'd5) ? STEP_TABLE[step] : 6'd0;
        for (int p = 0; p < 3; p++) begin
            if (ent[2*p +: 2] == DRV_HIGH && !highEn) begin
                ent[2*p +: 2] = DRV_OFF;
            end
        end
        return ent;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor3_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : motor3_pwm_gen
//  Description : Free-running PWM counter (0..PWM_PERIOD-1) and duty
//                compare. gateO is high while the counter is below dutyI,
//                so duty 0 never opens and duty PWM_PERIOD always opens.
//  Revision    : 1.0  initial release
// ============================================================================
module motor3_pwm_gen #(
    parameter int PWM_PERIOD = 50,
    parameter int DW         = 6
) (
    input  logic          clkI,
    input  logic          nRstI,
    input  logic [DW-1:0] dutyI,
    output logic          gateO
);

    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CW-1:0] c_cntLast = CW'(PWM_PERIOD - 1);

    logic [CW-1:0] r_cnt;

    // Wrapping period counter
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cntLast) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign gateO = (int'(r_cnt) < int'(dutyI));

endmodule
`default_nettype wire

// File: rtl/motor3_commutation_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : motor3_commutation_ctrl
//  Description : Six-step trapezoidal commutation controller. Converts
//                operator events into per-phase drive commands with NCO
//                step timing, high-side PWM gating, dead time and braking.
//                Optional soft start: define MOTOR3_SOFTSTART_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module motor3_commutation_ctrl
    import motor3_pkg::*;
#(
    parameter int CLK_HZ       = 1000000,
    parameter int STEP_DIV     = CLK_HZ / 6,
    parameter int FREQ_MIN     = FREQ_MIN_DFLT,
    parameter int FREQ_MAX     = FREQ_MAX_DFLT,
    parameter int FREQ_INIT    = 10,
    parameter int PWM_PERIOD   = 50,
    parameter int DEADTIME     = 2,
    parameter int BRAKE_CYCLES = 100000
) (
    input  logic       clkI,
    input  logic       nRstI,
    input  logic       m3startI,
    input  logic       m3forceStopI,
    input  logic       m3invRotateI,
    input  logic       m3freqINCi,
    input  logic       m3freqDECi,
    input  logic       m3powerINCi,
    input  logic       m3powerDECi,
    output logic [1:0] aDrvO,
    output logic [1:0] bDrvO,
    output logic [1:0] cDrvO,
    output logic [2:0] stepO,
    output logic       runO,
    output logic [9:0] freqO,
    output logic [5:0] powerO
);

    localparam int AW = $clog2(STEP_DIV + FREQ_MAX + 1);
    localparam int TW = $clog2(((BRAKE_CYCLES > DEADTIME) ? BRAKE_CYCLES : DEADTIME) + 1);

    localparam logic [AW-1:0] c_stepDiv   = AW'(STEP_DIV);
    localparam logic [TW-1:0] c_deadLast  = TW'(DEADTIME - 1);
    localparam logic [TW-1:0] c_brakeLast = TW'(BRAKE_CYCLES - 1);
    localparam logic [9:0]    c_freqMin   = 10'(FREQ_MIN);
    localparam logic [9:0]    c_freqMax   = 10'(FREQ_MAX);
    localparam logic [5:0]    c_powerMax  = 6'(PWM_PERIOD);

    // Event vector bit order: start, stop, freqInc, freqDec, powInc, powDec
    logic [5:0]    r_evtSync;
    logic [5:0]    r_evtPrev;
    logic          r_invSync;
    logic [5:0]    w_evt;
    logic          w_startEvt, w_stopEvt, w_fIncEvt, w_fDecEvt, w_pIncEvt, w_pDecEvt;
    logic          w_runEntry;

    motorState_t   r_state;
    logic [2:0]    r_step;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_accNext;
    logic [TW-1:0] r_timer;
    logic [9:0]    r_freq;
    logic [5:0]    r_power;
    logic [5:0]    w_duty;
    logic          w_gate;
    logic [5:0]    r_drv;

    // Register the raw controls once and keep the previous sample for edge detection
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_evtSync <= '0;
            r_evtPrev <= '0;
            r_invSync <= 1'b0;
        end else begin
            r_evtSync <= {m3powerDECi, m3powerINCi, m3freqDECi, m3freqINCi, m3forceStopI, m3startI};
            r_evtPrev <= r_evtSync;
            r_invSync <= m3invRotateI;
        end
    end

    assign w_evt      = r_evtSync & ~r_evtPrev;
    assign w_startEvt = w_evt[0];
    assign w_stopEvt  = w_evt[1];
    assign w_fIncEvt  = w_evt[2];
    assign w_fDecEvt  = w_evt[3];
    assign w_pIncEvt  = w_evt[4];
    assign w_pDecEvt  = w_evt[5];

    // Force stop beats a simultaneous start
    assign w_runEntry = (r_state == ST_IDLE) && w_startEvt && !w_stopEvt;
    assign w_accNext  = r_acc + AW'(r_freq);

    // Saturating frequency and power registers; INC+DEC together cancel
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_freq  <= 10'(FREQ_INIT);
            r_power <= '0;
        end else begin
            if (w_fIncEvt && !w_fDecEvt && r_freq < c_freqMax) begin
                r_freq <= r_freq + 10'd1;
            end else if (w_fDecEvt && !w_fIncEvt && r_freq > c_freqMin) begin
                r_freq <= r_freq - 10'd1;
            end
            if (w_pIncEvt && !w_pDecEvt && r_power < c_powerMax) begin
                r_power <= r_power + 6'd1;
            end else if (w_pDecEvt && !w_pIncEvt && r_power != 6'd0) begin
                r_power <= r_power - 6'd1;
            end
        end
    end

    // Main FSM: NCO step timing in RUN, timed DEAD and BRAKE phases
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_acc   <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_runEntry) begin
                        r_state <= ST_RUN;
                        r_step  <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_stopEvt) begin
                        r_state <= ST_DEAD;
                        r_timer <= '0;
                    end else if (w_accNext >= c_stepDiv) begin
                        r_acc <= w_accNext - c_stepDiv;
                        if (r_invSync) begin
                            r_step <= (r_step == 3'd0) ? 3'd5 : r_step - 3'd1;
                        end else begin
                            r_step <= (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
                        end
                    end else begin
                        r_acc <= w_accNext;
                    end
                end
                ST_DEAD: begin
                    if (r_timer == c_deadLast) begin
                        r_state <= ST_BRAKE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_BRAKE: begin
                    if (r_timer == c_brakeLast) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MOTOR3_SOFTSTART_EN
    logic [5:0] r_effPower;
    logic [9:0] r_ssTick;

    // Soft start: effective power ramps up one unit per 1000 cycles from RUN entry,
    // but follows a power decrease at once
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_effPower <= '0;
            r_ssTick   <= '0;
        end else if (w_runEntry) begin
            r_effPower <= '0;
            r_ssTick   <= '0;
        end else if (r_state == ST_RUN) begin
            r_ssTick <= (r_ssTick == 10'd999) ? 10'd0 : r_ssTick + 10'd1;
            if (r_power < r_effPower) begin
                r_effPower <= r_power;
            end else if (r_ssTick == 10'd999 && r_effPower < r_power) begin
                r_effPower <= r_effPower + 6'd1;
            end
        end
    end

    assign w_duty = r_effPower;
`else
    assign w_duty = r_power;
`endif

    motor3_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DW         (6)
    ) u_pwm (
        .clkI  (clkI),
        .nRstI (nRstI),
        .dutyI (w_duty),
        .gateO (w_gate)
    );

    // Registered drive outputs, one cycle behind state/step/PWM
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_drv <= '0;
        end else begin
            case (r_state)
                ST_RUN:   r_drv <= stepDrive(r_step, w_gate);
                ST_BRAKE: r_drv <= {DRV_LOW, DRV_LOW, DRV_LOW};
                default:  r_drv <= '0;
            endcase
        end
    end

    assign aDrvO  = r_drv[5:4];
    assign bDrvO  = r_drv[3:2];
    assign cDrvO  = r_drv[1:0];
    assign stepO  = r_step;
    assign runO   = (r_state == ST_RUN);
    assign freqO  = r_freq;
    assign powerO = r_power;

endmodule
`default_nettype wire
